// File: rtl/prog_sequencer.sv
// Fetch sequencer: program counter, Start/Ack run handshake, entry selection, stall, run counters.
// Optional watchdog enabled by defining SEQ_WATCHDOG_EN.
module prog_sequencer #(
  parameter int PC_W        = 10,
  parameter int OFS_W       = 8,
  parameter int NUM_PROGS   = 3,
  parameter int PROG_STRIDE = 256,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 4096,
  localparam int SEL_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchSrc,
  input  logic [PC_W-1:0]  LUTTarget,
  input  logic [OFS_W-1:0] RegOffset,
  input  logic             Stall,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Busy,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCt,
  output logic [CNT_W-1:0] InstrCt,
  output logic             Timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             wdog_hit_s;
  logic [PC_W-1:0]  entry_s;
  logic [PC_W-1:0]  rel_target_s;

  // Out-of-range selects fall back to entry 0; product is truncated to PC width.
  function automatic logic [PC_W-1:0] entry_of(input logic [SEL_W-1:0] sel);
    logic [31:0] prod;
    if (32'(sel) >= 32'(NUM_PROGS)) begin
      prod = 32'd0;
    end else begin
      prod = 32'(sel) * 32'(PROG_STRIDE);
    end
    return prod[PC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  assign entry_s      = entry_of(ProgSel);
  assign rel_target_s = pc_q + PC_W'($signed(RegOffset));

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;

  assign wdog_hit_s = (state_q == RUN) && (wd_q == WD_W'(WDOG_CYCLES - 1));

  always_comb begin
    wd_d = '0;
    to_d = to_q;
    if (state_q == RUN) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
    if ((state_q == IDLE || state_q == DONE) && Start) begin
      to_d = 1'b0;
    end else if (wdog_hit_s) begin
      to_d = 1'b1;
    end else begin
      to_d = to_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign Timeout = to_q;
`else
  assign wdog_hit_s = 1'b0;
  assign Timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = ARM;
          pc_d    = entry_s;
          cyc_d   = '0;
          ins_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      ARM: begin
        if (Start) begin
          pc_d = entry_s;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        cyc_d = sat_inc(cyc_q);
        if (Stall) begin
          pc_d = pc_q;
        end else if (Halt) begin
          state_d = DONE;
          ins_d   = sat_inc(ins_q);
        end else if (BranchEn && !BranchSrc) begin
          pc_d  = LUTTarget;
          ins_d = sat_inc(ins_q);
        end else if (BranchEn) begin
          pc_d  = rel_target_s;
          ins_d = sat_inc(ins_q);
        end else begin
          pc_d  = pc_q + PC_W'(1);
          ins_d = sat_inc(ins_q);
        end
        // A watchdog expiry freezes the PC unless the run is halting normally this cycle.
        if (wdog_hit_s && state_d == RUN) begin
          state_d = DONE;
          pc_d    = pc_q;
          ins_d   = ins_q;
        end else begin
          state_d = state_d;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    ack_d  = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Busy    = busy_q;
  assign Ack     = ack_q;
  assign CycleCt = cyc_q;
  assign InstrCt = ins_q;

endmodule
